// File: rtl/addac_seq.sv
// Word-level sequencer and round-robin arbiter for the bit-serial add/accumulate slice.
// It streams operand and accumulator bits LSB-first over W cycles and owns the accumulator.
module addac_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [1:0]   op0,
  input  logic [W-1:0] opnd0,
  input  logic [1:0]   op1,
  input  logic [W-1:0] opnd1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] acc_q,
  output logic         ovf,
  output logic         dp_a,
  output logic         dp_b,
  output logic         dp_sel0,
  output logic         dp_sel1,
  output logic         dp_cin,
  input  logic         dp_s,
  input  logic         dp_cout,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_op;
  logic [W-1:0]   r_opsh;
  logic [W-1:0]   r_accsh;
  logic [W-1:0]   r_acc_q;
  logic [CW-1:0]  r_cnt;
  logic           r_carry;
  logic           r_winner;
  logic           r_rr_last;
  logic           r_ovf;

  logic           w_accept;
  logic           w_last;
  logic           w_winner;
  logic [1:0]     w_op;
  logic [W-1:0]   w_opnd;

  // On a tie, serve the requester that was not served last.
  assign w_winner = (req == 2'b10) ? 1'b1 :
                    (req == 2'b01) ? 1'b0 : ~r_rr_last;
  assign w_op     = w_winner ? op1 : op0;
  assign w_opnd   = w_winner ? opnd1 : opnd0;

  assign acc_q     = r_acc_q;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    gnt      = 2'b00;
    busy     = 1'b0;
    done     = 1'b0;
    done_id  = 1'b0;
    dp_a     = 1'b0;
    dp_b     = 1'b0;
    dp_sel0  = 1'b0;
    dp_sel1  = 1'b0;
    dp_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        dp_a    = r_opsh[0];
        dp_b    = r_accsh[0];
        dp_cin  = r_carry;
        // Opcode encoding: bit 1 inverts the operand, odd parity selects the adder.
        dp_sel0 = r_op[1];
        dp_sel1 = ^r_op;
        if (r_cnt == '0) gnt = r_winner ? 2'b10 : 2'b01;
        if (r_cnt == LAST) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        done_id = r_winner;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= 2'b00;
      r_opsh    <= '0;
      r_accsh   <= '0;
      r_acc_q   <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_winner  <= 1'b0;
      r_rr_last <= 1'b1;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_opsh    <= w_opnd;
      r_accsh   <= r_acc_q;
      r_cnt     <= '0;
      r_carry   <= (w_op == OP_SUB);
      r_winner  <= w_winner;
      r_rr_last <= w_winner;
    end else if (r_state == S_RUN) begin
      r_accsh <= {dp_s, r_accsh[W-1:1]};
      r_opsh  <= {1'b0, r_opsh[W-1:1]};
      r_carry <= dp_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_acc_q <= {dp_s, r_accsh[W-1:1]};
        r_ovf   <= dp_sel1 & (dp_cin ^ dp_cout);
      end
    end
  end

endmodule

// File: tb/tb_addac_seq.sv
// Directed bench for addac_seq: a behavioural slice closes the loop, and each task
// checks one scenario against hand-computed results.
module tb_addac_seq;

  localparam int W = 8;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_LOADN = 2'b11;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req;
  logic [1:0]   op0;
  logic [W-1:0] opnd0;
  logic [1:0]   op1;
  logic [W-1:0] opnd1;
  logic [1:0]   gnt;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] acc_q;
  logic         ovf;
  logic         dp_a;
  logic         dp_b;
  logic         dp_sel0;
  logic         dp_sel1;
  logic         dp_cin;
  logic         dp_s;
  logic         dp_cout;
  logic [1:0]   dbg_state;

  int checks;
  int errors;
  logic [W-1:0] prev_acc;

  addac_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .op0(op0), .opnd0(opnd0), .op1(op1), .opnd1(opnd1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .acc_q(acc_q), .ovf(ovf),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sel0(dp_sel0), .dp_sel1(dp_sel1),
    .dp_cin(dp_cin), .dp_s(dp_s), .dp_cout(dp_cout),
    .dbg_state(dbg_state)
  );

  // Combinational slice.
  logic w_x;
  assign w_x     = dp_a ^ dp_sel0;
  assign dp_s    = dp_sel1 ? (w_x ^ dp_b ^ dp_cin) : w_x;
  assign dp_cout = (w_x & dp_b) | (w_x & dp_cin) | (dp_b & dp_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from an idle sequencer and check it through to completion.
  task automatic do_op(input int id, input logic [1:0] op, input logic [W-1:0] opnd,
                       input logic [W-1:0] exp_acc, input logic exp_ovf, input string name);
    logic [1:0] exp_gnt;
    logic       exp_sel0;
    logic       exp_sel1;
    int         run_bad;
    int         sel_bad;
    exp_gnt  = (id == 0) ? 2'b01 : 2'b10;
    exp_sel0 = (op == OP_SUB) || (op == OP_LOADN);
    exp_sel1 = (op == OP_ADD) || (op == OP_SUB);
    if (id == 0) begin op0 = op; opnd0 = opnd; end
    else         begin op1 = op; opnd1 = opnd; end
    req = exp_gnt;
    step();
    req = 2'b00;
    checks++;
    if (gnt !== exp_gnt) begin
      errors++;
      $display("FAIL %s gnt: got %b want %b", name, gnt, exp_gnt);
    end
    checks++;
    if (acc_q !== prev_acc) begin
      errors++;
      $display("FAIL %s acc_q_hold: got %h want %h", name, acc_q, prev_acc);
    end
    run_bad = 0;
    sel_bad = 0;
    for (int c = 1; c <= W; c++) begin
      if (c > 1) begin
        step();
        if (gnt !== 2'b00) run_bad++;
      end
      if (busy !== 1'b1 || done !== 1'b0) run_bad++;
      if (dp_sel0 !== exp_sel0 || dp_sel1 !== exp_sel1) sel_bad++;
    end
    checks++;
    if (run_bad != 0) begin
      errors++;
      $display("FAIL %s run_phase: got %0d bad cycles want 0", name, run_bad);
    end
    checks++;
    if (sel_bad != 0) begin
      errors++;
      $display("FAIL %s slice_sel: got %0d bad cycles want 0", name, sel_bad);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || done_id !== id[0]) begin
      errors++;
      $display("FAIL %s done: got done=%b busy=%b id=%b want 1 0 %0d",
               name, done, busy, done_id, id);
    end
    checks++;
    if (acc_q !== exp_acc || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s result: got acc=%h ovf=%b want acc=%h ovf=%b",
               name, acc_q, ovf, exp_acc, exp_ovf);
    end
    checks++;
    if ({dp_a, dp_b, dp_sel0, dp_sel1, dp_cin} !== 5'b0) begin
      errors++;
      $display("FAIL %s dp_in_done: got %b want 00000", name,
               {dp_a, dp_b, dp_sel0, dp_sel1, dp_cin});
    end
    prev_acc = exp_acc;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    prev_acc = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    op0   = OP_LOAD;
    op1   = OP_LOAD;
    opnd0 = '0;
    opnd1 = '0;
    repeat (3) step();
    checks++;
    if ({gnt, busy, done, done_id, ovf} !== 6'b0 || acc_q !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b id=%b acc=%h ovf=%b st=%0d want all 0",
               gnt, busy, done, done_id, acc_q, ovf, dbg_state);
    end
    checks++;
    if ({dp_a, dp_b, dp_sel0, dp_sel1, dp_cin} !== 5'b0) begin
      errors++;
      $display("FAIL reset_dp: got %b want 00000", {dp_a, dp_b, dp_sel0, dp_sel1, dp_cin});
    end
    rst_n = 1'b1;
    step();
    prev_acc = '0;
  endtask

  task automatic test_load();
    do_op(0, OP_LOAD, 8'h5A, 8'h5A, 1'b0, "load_5a");
  endtask

  task automatic test_add();
    do_op(0, OP_LOAD, 8'h01, 8'h01, 1'b0, "add_setup");
    do_op(0, OP_ADD,  8'h7F, 8'h80, 1'b1, "add_7f");
    do_op(1, OP_ADD,  8'h80, 8'h00, 1'b1, "add_80");
  endtask

  task automatic test_sub();
    do_op(0, OP_LOAD, 8'h01, 8'h01, 1'b0, "sub_setup1");
    do_op(0, OP_SUB,  8'h03, 8'hFE, 1'b0, "sub_03");
    do_op(1, OP_LOAD, 8'h80, 8'h80, 1'b0, "sub_setup2");
    do_op(1, OP_SUB,  8'h01, 8'h7F, 1'b1, "sub_01");
  endtask

  task automatic test_loadn();
    do_op(0, OP_LOADN, 8'h0F, 8'hF0, 1'b0, "loadn_0f");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_acc [4];
    logic [1:0]   exp_gnt;
    int           n;
    exp_acc[0] = 8'h01;
    exp_acc[1] = 8'h03;
    exp_acc[2] = 8'h04;
    exp_acc[3] = 8'h06;
    apply_reset();
    op0   = OP_ADD;
    opnd0 = 8'h01;
    op1   = OP_ADD;
    opnd1 = 8'h02;
    req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      do begin
        step();
        n++;
      end while (gnt == 2'b00 && n < 20);
      checks++;
      if (gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, exp_gnt);
      end
      if (k == 3) req = 2'b00;
      repeat (W) step();
      checks++;
      if (done !== 1'b1 || done_id !== exp_gnt[1] || acc_q !== exp_acc[k]) begin
        errors++;
        $display("FAIL rr_done%0d: got done=%b id=%b acc=%h want 1 %b %h",
                 k, done, done_id, acc_q, exp_gnt[1], exp_acc[k]);
      end
    end
    step();
    prev_acc = exp_acc[3];
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    do_op(0, OP_LOAD, 8'h33, 8'h33, 1'b0, "abort_setup");
    op0   = OP_LOAD;
    opnd0 = 8'h44;
    req   = 2'b01;
    step();
    req = 2'b00;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, busy, done, done_id, ovf} !== 6'b0 || acc_q !== '0 ||
        {dp_a, dp_b, dp_sel0, dp_sel1, dp_cin} !== 5'b0) begin
      errors++;
      $display("FAIL abort_outputs: got gnt=%b busy=%b done=%b acc=%h dp=%b want all 0",
               gnt, busy, done, acc_q, {dp_a, dp_b, dp_sel0, dp_sel1, dp_cin});
    end
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (done !== 1'b0) done_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done cycles want 0", done_seen);
    end
    prev_acc = '0;
    do_op(0, OP_LOAD, 8'h11, 8'h11, 1'b0, "after_abort");
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    prev_acc = '0;
    rst_n    = 1'b0;
    req      = 2'b00;
    op0      = OP_LOAD;
    op1      = OP_LOAD;
    opnd0    = '0;
    opnd1    = '0;
    test_reset();
    test_load();
    test_add();
    test_sub();
    test_loadn();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addac_seq.md
Name: addac_seq

Overview:
- Word-level sequencer and two-port arbiter for the bit-serial add/accumulate slice.
- Accepts W-bit operations (LOAD, LOADN, ADD, SUB) from two requesters and arbitrates them round-robin.
- Streams operand and accumulator bits LSB-first through the slice over W cycles, chaining the carry between bits.
- Owns the W-bit accumulator and reports completion and signed overflow.

Parameters:
W, 8, operand/accumulator width in bits (W >= 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  2  request per requester (bit i = requester i)
op0  in  2  requester 0 opcode: 00 LOAD, 01 ADD, 10 SUB, 11 LOADN
opnd0  in  W  requester 0 operand
op1  in  2  requester 1 opcode
opnd1  in  W  requester 1 operand
gnt  out  2  one-hot grant pulse
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
done_id  out  1  requester served, valid with done
acc_q  out  W  committed accumulator value
ovf  out  1  signed overflow of last ADD/SUB
dp_a  out  1  slice operand bit
dp_b  out  1  slice accumulator bit
dp_sel0  out  1  slice invert-operand select
dp_sel1  out  1  slice select: 1 = adder path, 0 = pass path
dp_cin  out  1  slice carry in
dp_s  in  1  slice sum/pass bit
dp_cout  in  1  slice carry out

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Slice contract (combinational, same cycle):
  - x = dp_a ^ dp_sel0
  - dp_s = dp_sel1 ? x^dp_b^dp_cin : x
  - dp_cout = maj(x, dp_b, dp_cin)
- Opcode to slice controls:
  - LOAD: sel0=0, sel1=0
  - LOADN: sel0=1, sel1=0
  - ADD: sel0=0, sel1=1, initial carry 0
  - SUB: sel0=1, sel1=1, initial carry 1
- FSM states: IDLE, RUN, DONE.
- IDLE, no req: remain in IDLE.
- IDLE, any req bit set at edge T: accept.
  - Latch the winner's opcode and operand into the op shift register.
  - Copy acc_q into the acc shift register.
  - Set carry to (op==SUB), bit counter to 0; go to RUN.
- Arbitration:
  - Single requester wins outright.
  - Both requesting: grant the requester not granted last (rr_last); rr_last updates on accept.
  - rr_last resets to 1, so requester 0 wins the first tie.
- RUN occupies cycles T+1..T+W:
  - gnt[winner]=1 only in cycle T+1; busy=1 throughout.
  - Each cycle drive dp_a=opsh[0], dp_b=accsh[0], dp_cin=carry, sel0/sel1 per opcode.
  - At the edge: accsh <= {dp_s, accsh[W-1:1]}; opsh shifts right; carry <= dp_cout; counter++.
  - On counter==W-1: record ovf = (ADD/SUB) ? dp_cin ^ dp_cout : 0; go to DONE.
- DONE is cycle T+W+1:
  - done=1, done_id=winner, acc_q=accsh (updated at entry), busy=0; go to IDLE.
- Requester protocol:
  - Operand and opcode are sampled only at the accept edge.
  - A requester must drop req in its gnt cycle; a req still high in IDLE is served again.
  - req is ignored during RUN and DONE.
- acc_q and ovf change only on entering DONE. Arithmetic is modulo 2^W.
- dp_* outputs are 0 in IDLE and DONE.
- Reset values: state IDLE; acc_q=0, ovf=0, gnt=0, done=0, done_id=0, busy=0; dp_*=0; rr_last=1; carry and counter 0.
- Reset mid-RUN: aborts immediately, no done pulse, acc_q=0; the next request is served normally.

Test Plan:
- (W=8 throughout.) Reset; req0 LOAD 0x5A at T -> gnt=01 at T+1, busy T+1..T+8, done=1, done_id=0 at T+9, acc_q=0x5A, ovf=0.
- acc=0x01, ADD 0x7F -> acc_q=0x80, ovf=1. Then ADD 0x80 -> acc_q=0x00, ovf=1.
- acc=0x01, SUB 0x03 -> acc_q=0xFE, ovf=0. acc=0x80, SUB 0x01 -> acc_q=0x7F, ovf=1.
- acc=any, LOADN 0x0F -> acc_q=0xF0, ovf=0. dp_sel1=0 and dp_sel0=1 throughout RUN.
- After reset, req=11 held with op0=ADD 1 and op1=ADD 2 from acc 0 -> grants 0,1,0,1. done_id alternates; acc_q 1,3,4,6.
- rst_n low during RUN bit 4 after a prior LOAD 0x33 -> all outputs 0 immediately, no done, acc_q=0. A following LOAD 0x11 completes normally in 9 cycles.
